// File: rtl/trig_pkg.sv
// rtl/trig_pkg.sv - capture controller state encoding and trigger source bit positions
package trig_pkg;

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

  localparam int TRIG_UART = 0;
  localparam int TRIG_SPI  = 1;
  localparam int TRIG_CH   = 2;

endpackage

// File: rtl/trig_sel.sv
// rtl/trig_sel.sv - trigger source masking and pending-trigger latch
module trig_sel
  import trig_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] trig_src,
  input  logic       UARTtrig,
  input  logic       SPItrig,
  input  logic       CHtrig,
  input  logic       force_trig,
  input  logic       armed,
  input  logic       consume,
  output logic       pending,
  output logic       trig_hit
);

  logic [2:0] pulses;
  logic       qual;

  always_comb begin
    pulses            = '0;
    pulses[TRIG_UART] = UARTtrig;
    pulses[TRIG_SPI]  = SPItrig;
    pulses[TRIG_CH]   = CHtrig;
  end

  assign qual     = armed & ((|(trig_src & pulses)) | force_trig);
  // A pulse coinciding with a sample strobe must count for that very sample.
  assign trig_hit = pending | qual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (!armed || consume) begin
      pending <= 1'b0;
    end else if (qual) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/trig_capture_ctrl.sv
// rtl/trig_capture_ctrl.sv - circular sample buffer capture FSM with pre/post trigger counting
module trig_capture_ctrl
  import trig_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              wrt_smpl,
  input  logic [2:0]        trig_src,
  input  logic              UARTtrig,
  input  logic              SPItrig,
  input  logic              CHtrig,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              capture_clr,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] pos_eff;
  logic [ADDR_W-1:0] pos_in;
  logic              pending, trig_hit, consume;
  logic              fill_done, post_done, start;

  assign pos_in    = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
  assign start     = (state == IDLE) && run;
  assign we        = wrt_smpl && ((state == FILL) || (state == ARMED) || (state == POST));
  assign consume   = we && (state == ARMED) && trig_hit;
  // Pre-trigger region leaves exactly pos_eff slots for the post-trigger samples.
  assign fill_done = we && (state == FILL) && ((pre_cnt + CNT_W'(1)) == (DEPTH - CNT_W'(pos_eff)));
  assign post_done = we && (state == POST) && ((post_cnt + ADDR_W'(1)) == pos_eff);

  assign armed        = (state == ARMED);
  assign capture_done = (state == DONE);
  assign triggered    = pending || (state == POST) || (state == DONE);

  trig_sel u_trig_sel (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_src   (trig_src),
    .UARTtrig   (UARTtrig),
    .SPItrig    (SPItrig),
    .CHtrig     (CHtrig),
    .force_trig (force_trig),
    .armed      (armed),
    .consume    (consume),
    .pending    (pending),
    .trig_hit   (trig_hit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FILL;
      FILL:    if (!run) state_nxt = IDLE;
               else if (fill_done) state_nxt = ARMED;
      ARMED:   if (!run) state_nxt = IDLE;
               else if (consume) state_nxt = (pos_eff == ADDR_W'(1)) ? DONE : POST;
      POST:    if (!run) state_nxt = IDLE;
               else if (post_done) state_nxt = DONE;
      DONE:    if (capture_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      waddr     <= '0;
      trig_addr <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      pos_eff   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        waddr    <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
        pos_eff  <= pos_in;
      end else if (we) begin
        waddr <= waddr + ADDR_W'(1);
        if (state == FILL) pre_cnt <= pre_cnt + CNT_W'(1);
        if (consume) begin
          trig_addr <= waddr;
          post_cnt  <= ADDR_W'(1);
        end else if (state == POST) begin
          post_cnt <= post_cnt + ADDR_W'(1);
        end
      end
    end
  end

endmodule
